// File: rtl/race_pkg.sv
// Shared race state codes, winner codes and state-bus width for the game
// sequencer, the physics engines and the display path.
package race_pkg;

  localparam int STATE_W = 3;

  // Code 2 is reserved; codes 2 and 7 are never driven.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_SETTING   = 3'd1,
    ST_COUNTDOWN = 3'd3,
    ST_RACING    = 3'd4,
    ST_PAUSE     = 3'd5,
    ST_FINISH    = 3'd6
  } race_state_e;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_CAR1 = 2'd1;
  localparam logic [1:0] WIN_CAR2 = 2'd2;
  localparam logic [1:0] WIN_TIE  = 2'd3;

endpackage

// File: rtl/tick_divider.sv
// Enabled prescaler: one-cycle tick every DIV enabled cycles; clr restarts the
// count and holds when en is low so partial periods are kept.
module tick_divider #(
  parameter int DIV = 10,
  parameter int W   = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [W-1:0] TERM = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == TERM) ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && !clr && (cnt_q == TERM);

endmodule

// File: rtl/race_controller.sv
// Game sequencer: drives the shared state bus, countdown, race timer and winner.
// Defining RACE_TIMEOUT_EN ends a race with no winner when the timer hits TIMEOUT_CS.
module race_controller #(
  parameter int CLK_FREQ      = 100_000_000,
  parameter int COUNTDOWN_SEC = 3,
  parameter int TIMEOUT_CS    = 60000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_pulse,
  input  logic        pause_pulse,
  input  logic        settings_done,
  input  logic        p1_finish,
  input  logic        p2_finish,
  output logic [2:0]  state,
  output logic [2:0]  countdown_val,
  output logic [15:0] race_time_cs,
  output logic [1:0]  winner,
  output logic        state_change
);
  import race_pkg::*;

  localparam int             PRESC_W     = $clog2(CLK_FREQ);
  localparam int             CS_DIV      = CLK_FREQ / 100;
  localparam logic [2:0]     CD_INIT     = 3'(COUNTDOWN_SEC);
  localparam logic [15:0]    TIMEOUT_VAL = 16'(TIMEOUT_CS);
`ifdef RACE_TIMEOUT_EN
  localparam bit             TIMEOUT_ON  = 1'b1;
`else
  localparam bit             TIMEOUT_ON  = 1'b0;
`endif

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  race_state_e state_q, state_d;
  logic [2:0]  cd_q, cd_d;
  logic [15:0] time_q, time_d;
  logic [1:0]  win_q, win_d;
  logic        chg_q, chg_d;

  logic        sec_tick, cs_tick;
  logic        enter_cd;
  logic [15:0] time_inc;

  // Both prescalers restart on countdown entry so every race times from zero.
  assign enter_cd = (state_q == ST_SETTING) && settings_done;
  assign time_inc = sat_inc16(time_q);

  tick_divider #(.DIV(CLK_FREQ), .W(PRESC_W)) u_sec_div (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q == ST_COUNTDOWN),
    .clr  (enter_cd),
    .tick (sec_tick)
  );

  tick_divider #(.DIV(CS_DIV), .W(PRESC_W)) u_cs_div (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q == ST_RACING),
    .clr  (enter_cd),
    .tick (cs_tick)
  );

  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    time_d  = time_q;
    win_d   = win_q;
    case (state_q)
      ST_IDLE: begin
        if (start_pulse) state_d = ST_SETTING;
      end
      ST_SETTING: begin
        if (settings_done) begin
          state_d = ST_COUNTDOWN;
          cd_d    = CD_INIT;
          time_d  = '0;
          win_d   = WIN_NONE;
        end
      end
      ST_COUNTDOWN: begin
        if (sec_tick) begin
          if (cd_q <= 3'd1) begin
            state_d = ST_RACING;
            cd_d    = '0;
          end else begin
            cd_d = cd_q - 3'd1;
          end
        end
      end
      ST_RACING: begin
        if (cs_tick) time_d = time_inc;
        // Finish beats timeout, timeout beats pause.
        if (p1_finish || p2_finish) begin
          state_d = ST_FINISH;
          win_d   = {p2_finish, p1_finish};
        end else if (TIMEOUT_ON && cs_tick && (time_inc == TIMEOUT_VAL)) begin
          state_d = ST_FINISH;
          win_d   = WIN_NONE;
        end else if (pause_pulse) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (start_pulse)      state_d = ST_IDLE;
        else if (pause_pulse) state_d = ST_RACING;
      end
      ST_FINISH: begin
        if (start_pulse) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    chg_d = (state_d != state_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cd_q    <= '0;
      time_q  <= '0;
      win_q   <= WIN_NONE;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cd_q    <= cd_d;
      time_q  <= time_d;
      win_q   <= win_d;
      chg_q   <= chg_d;
    end
  end

  assign state         = state_q;
  assign countdown_val = cd_q;
  assign race_time_cs  = time_q;
  assign winner        = win_q;
  assign state_change  = chg_q;

endmodule

// File: tb/tb_race_controller.sv
// Directed bench for race_controller with CLK_FREQ=1000 (cs tick every 10
// cycles, second tick every 1000) and TIMEOUT_CS=20.
module tb_race_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_pulse = 1'b0;
  logic        pause_pulse = 1'b0;
  logic        settings_done = 1'b0;
  logic        p1_finish = 1'b0;
  logic        p2_finish = 1'b0;
  logic [2:0]  state;
  logic [2:0]  countdown_val;
  logic [15:0] race_time_cs;
  logic [1:0]  winner;
  logic        state_change;

  int total = 0;
  int bad   = 0;

  race_controller #(
    .CLK_FREQ      (1000),
    .COUNTDOWN_SEC (3),
    .TIMEOUT_CS    (20)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start_pulse   (start_pulse),
    .pause_pulse   (pause_pulse),
    .settings_done (settings_done),
    .p1_finish     (p1_finish),
    .p2_finish     (p2_finish),
    .state         (state),
    .countdown_val (countdown_val),
    .race_time_cs  (race_time_cs),
    .winner        (winner),
    .state_change  (state_change)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are observed 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_racing();
    start_pulse = 1'b1; settings_done = 1'b1;
    step();
    start_pulse = 1'b0;
    step();
    settings_done = 1'b0;
    repeat (3000) step();
  endtask

  task automatic go_idle();
    start_pulse = 1'b1;
    step();
    start_pulse = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
    total++; if (countdown_val !== 3'd0) begin bad++; $display("FAIL reset_cd got=%0d exp=0", countdown_val); end
    total++; if (race_time_cs !== 16'd0) begin bad++; $display("FAIL reset_time got=%0d exp=0", race_time_cs); end
    total++; if (winner !== 2'd0) begin bad++; $display("FAIL reset_winner got=%0d exp=0", winner); end
    total++; if (state_change !== 1'b0) begin bad++; $display("FAIL reset_chg got=%0d exp=0", state_change); end
  endtask

  task automatic test_startup();
    int pulses;
    start_pulse = 1'b1; settings_done = 1'b1;
    step();
    start_pulse = 1'b0;
    total++; if (state !== 3'd1) begin bad++; $display("FAIL setting_state got=%0d exp=1", state); end
    total++; if (state_change !== 1'b1) begin bad++; $display("FAIL setting_chg got=%0d exp=1", state_change); end
    step();
    settings_done = 1'b0;
    total++; if (state !== 3'd3) begin bad++; $display("FAIL cd_state got=%0d exp=3", state); end
    total++; if (state_change !== 1'b1) begin bad++; $display("FAIL cd_chg got=%0d exp=1", state_change); end
    total++; if (countdown_val !== 3'd3) begin bad++; $display("FAIL cd_entry got=%0d exp=3", countdown_val); end
    pulses = 0;
    repeat (500) begin step(); if (state_change) pulses++; end
    // Pause and start are ignored during countdown.
    pause_pulse = 1'b1; start_pulse = 1'b1;
    step(); if (state_change) pulses++;
    pause_pulse = 1'b0; start_pulse = 1'b0;
    total++; if (state !== 3'd3) begin bad++; $display("FAIL cd_ignore got=%0d exp=3", state); end
    repeat (498) begin step(); if (state_change) pulses++; end
    total++; if (countdown_val !== 3'd3) begin bad++; $display("FAIL cd_999 got=%0d exp=3", countdown_val); end
    step(); if (state_change) pulses++;
    total++; if (countdown_val !== 3'd2) begin bad++; $display("FAIL cd_1000 got=%0d exp=2", countdown_val); end
    repeat (1000) begin step(); if (state_change) pulses++; end
    total++; if (countdown_val !== 3'd1) begin bad++; $display("FAIL cd_2000 got=%0d exp=1", countdown_val); end
    repeat (999) begin step(); if (state_change) pulses++; end
    total++; if (state !== 3'd3) begin bad++; $display("FAIL cd_2999 got=%0d exp=3", state); end
    step(); if (state_change) pulses++;
    total++; if (state !== 3'd4) begin bad++; $display("FAIL race_entry got=%0d exp=4", state); end
    total++; if (countdown_val !== 3'd0) begin bad++; $display("FAIL race_cd got=%0d exp=0", countdown_val); end
    total++; if (pulses !== 1) begin bad++; $display("FAIL cd_chg_count got=%0d exp=1", pulses); end
  endtask

  task automatic test_finish_p2();
    repeat (150) step();
    total++; if (race_time_cs !== 16'd15) begin bad++; $display("FAIL race_time150 got=%0d exp=15", race_time_cs); end
    start_pulse = 1'b1;
    step();
    start_pulse = 1'b0;
    total++; if (state !== 3'd4) begin bad++; $display("FAIL race_ignore_start got=%0d exp=4", state); end
    p2_finish = 1'b1;
    step();
    p2_finish = 1'b0;
    total++; if (state !== 3'd6) begin bad++; $display("FAIL p2_state got=%0d exp=6", state); end
    total++; if (winner !== 2'd2) begin bad++; $display("FAIL p2_winner got=%0d exp=2", winner); end
    repeat (40) step();
    total++; if (race_time_cs !== 16'd15) begin bad++; $display("FAIL p2_frozen got=%0d exp=15", race_time_cs); end
    go_idle();
    total++; if (state !== 3'd0) begin bad++; $display("FAIL finish_to_idle got=%0d exp=0", state); end
    total++; if (winner !== 2'd2 || race_time_cs !== 16'd15) begin
      bad++; $display("FAIL idle_visible got=%0d/%0d exp=2/15", winner, race_time_cs); end
  endtask

  task automatic test_tie();
    go_racing();
    repeat (33) step();
    p1_finish = 1'b1; p2_finish = 1'b1;
    step();
    p1_finish = 1'b0; p2_finish = 1'b0;
    total++; if (state !== 3'd6 || winner !== 2'd3) begin
      bad++; $display("FAIL tie got=%0d/%0d exp=6/3", state, winner); end
    total++; if (race_time_cs !== 16'd3) begin bad++; $display("FAIL tie_time got=%0d exp=3", race_time_cs); end
    go_idle();
  endtask

  task automatic test_finish_over_pause();
    go_racing();
    repeat (12) step();
    p1_finish = 1'b1; pause_pulse = 1'b1;
    step();
    p1_finish = 1'b0; pause_pulse = 1'b0;
    total++; if (state !== 3'd6 || winner !== 2'd1) begin
      bad++; $display("FAIL fin_pause got=%0d/%0d exp=6/1", state, winner); end
    go_idle();
  endtask

  task automatic test_entry_clear();
    start_pulse = 1'b1; settings_done = 1'b1;
    step();
    start_pulse = 1'b0;
    step();
    settings_done = 1'b0;
    total++; if (winner !== 2'd0 || race_time_cs !== 16'd0) begin
      bad++; $display("FAIL entry_clear got=%0d/%0d exp=0/0", winner, race_time_cs); end
    repeat (3000) step();
    total++; if (state !== 3'd4) begin bad++; $display("FAIL entry_race got=%0d exp=4", state); end
  endtask

  task automatic test_pause_resume();
    repeat (75) step();
    total++; if (race_time_cs !== 16'd7) begin bad++; $display("FAIL pre_pause got=%0d exp=7", race_time_cs); end
    pause_pulse = 1'b1;
    step();
    pause_pulse = 1'b0;
    total++; if (state !== 3'd5) begin bad++; $display("FAIL pause_state got=%0d exp=5", state); end
    p1_finish = 1'b1;
    repeat (5000) step();
    p1_finish = 1'b0;
    total++; if (state !== 3'd5 || race_time_cs !== 16'd7) begin
      bad++; $display("FAIL pause_hold got=%0d/%0d exp=5/7", state, race_time_cs); end
    pause_pulse = 1'b1;
    step();
    pause_pulse = 1'b0;
    total++; if (state !== 3'd4 || race_time_cs !== 16'd7) begin
      bad++; $display("FAIL resume got=%0d/%0d exp=4/7", state, race_time_cs); end
    // Prescaler held at 6 of 10, so only four more cycles to the next tick.
    repeat (3) step();
    total++; if (race_time_cs !== 16'd7) begin bad++; $display("FAIL resume_p3 got=%0d exp=7", race_time_cs); end
    step();
    total++; if (race_time_cs !== 16'd8) begin bad++; $display("FAIL resume_p4 got=%0d exp=8", race_time_cs); end
  endtask

  task automatic test_abort();
    pause_pulse = 1'b1;
    step();
    pause_pulse = 1'b0;
    start_pulse = 1'b1; pause_pulse = 1'b1;
    step();
    start_pulse = 1'b0; pause_pulse = 1'b0;
    total++; if (state !== 3'd0) begin bad++; $display("FAIL abort got=%0d exp=0", state); end
    total++; if (race_time_cs !== 16'd8) begin bad++; $display("FAIL abort_time got=%0d exp=8", race_time_cs); end
    start_pulse = 1'b1; settings_done = 1'b1;
    step();
    start_pulse = 1'b0;
    step();
    settings_done = 1'b0;
    total++; if (state !== 3'd3 || race_time_cs !== 16'd0) begin
      bad++; $display("FAIL abort_reentry got=%0d/%0d exp=3/0", state, race_time_cs); end
  endtask

  task automatic test_reset_mid_countdown();
    repeat (1500) step();
    total++; if (countdown_val !== 3'd2) begin bad++; $display("FAIL mid_cd got=%0d exp=2", countdown_val); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (state !== 3'd0 || countdown_val !== 3'd0 || race_time_cs !== 16'd0 ||
                 winner !== 2'd0 || state_change !== 1'b0) begin
      bad++; $display("FAIL rst_cd got=%0d/%0d/%0d/%0d/%0d exp=0/0/0/0/0",
                      state, countdown_val, race_time_cs, winner, state_change); end
  endtask

  task automatic test_reset_mid_race();
    go_racing();
    repeat (57) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (state !== 3'd0 || race_time_cs !== 16'd0 || state_change !== 1'b0) begin
      bad++; $display("FAIL rst_race got=%0d/%0d/%0d exp=0/0/0", state, race_time_cs, state_change); end
  endtask

  task automatic test_timeout();
    go_racing();
`ifdef RACE_TIMEOUT_EN
    repeat (199) step();
    total++; if (state !== 3'd4 || race_time_cs !== 16'd19) begin
      bad++; $display("FAIL pre_timeout got=%0d/%0d exp=4/19", state, race_time_cs); end
    step();
    total++; if (state !== 3'd6 || race_time_cs !== 16'd20 || winner !== 2'd0) begin
      bad++; $display("FAIL timeout got=%0d/%0d/%0d exp=6/20/0", state, race_time_cs, winner); end
    repeat (30) step();
    total++; if (race_time_cs !== 16'd20) begin bad++; $display("FAIL timeout_frozen got=%0d exp=20", race_time_cs); end
`else
    repeat (250) step();
    total++; if (state !== 3'd4 || race_time_cs !== 16'd25) begin
      bad++; $display("FAIL no_timeout got=%0d/%0d exp=4/25", state, race_time_cs); end
    p1_finish = 1'b1;
    step();
    p1_finish = 1'b0;
    total++; if (state !== 3'd6 || winner !== 2'd1) begin
      bad++; $display("FAIL no_timeout_fin got=%0d/%0d exp=6/1", state, winner); end
`endif
    go_idle();
  endtask

  initial begin
    test_reset();
    test_startup();
    test_finish_p2();
    test_tie();
    test_finish_over_pause();
    test_entry_clear();
    test_pause_resume();
    test_abort();
    test_reset_mid_countdown();
    test_reset_mid_race();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
